// File: rtl/sram_ctrl_pkg.sv
// Shared types, default timing and sizing helpers for the SRAM array sequencer.
// Default pulse and gap widths assume a 1 GHz clk and 10 ns wordline/recovery windows.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        PULSE   = 2'd2,
        RECOVER = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int CLK_PERIOD_PS     = 1000;
    localparam int WL_PULSE_PS       = 10000;
    localparam int GAP_PS            = 10000;
    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_WL_CYCLES     = WL_PULSE_PS / CLK_PERIOD_PS;
    localparam int DEF_SENSE_CYCLES  = 2;
    localparam int DEF_GAP_CYCLES    = GAP_PS / CLK_PERIOD_PS;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_row_decoder.sv
// Combinational row decoder: one-hot wordline select plus an in-range flag
// for arrays whose DEPTH need not be a power of two.
module sram_row_decoder
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
)(
    input  logic [AW-1:0]    i_addr,
    input  logic             i_en,
    output logic [DEPTH-1:0] o_onehot,
    output logic             o_in_range
);

    logic [DEPTH-1:0] w_hit;

    // Address match per row; addresses at or above DEPTH hit nothing.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit[i] = (i_addr == AW'(i));
        end
    end

    assign o_in_range = |w_hit;
    assign o_onehot   = i_en ? w_hit : '0;

endmodule

// File: rtl/sram_array_ctrl.sv
// Request sequencer for a DEPTH x WIDTH mixed-signal SRAM array: turns one
// valid/ready word request into timed setup, wordline pulse and recovery phases.
module sram_array_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int WL_CYCLES    = DEF_WL_CYCLES,
    parameter int SENSE_CYCLES = DEF_SENSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [WIDTH-1:0] req_wmask,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [DEPTH-1:0] row_wr,
    output logic [DEPTH-1:0] row_rd,
    output logic [WIDTH-1:0] wd_en,
    output logic [WIDTH-1:0] wd_data,
    output logic             sa_en,
    input  logic [WIDTH-1:0] sa_out
);

    localparam int CW = bits_for(max3(SETUP_CYCLES, WL_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] WL_LD    = CW'(WL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SENSE_TH = CW'(SENSE_CYCLES);

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             w_acc;
    op_e              r_op;
    logic [AW-1:0]    r_addr, w_addr;
    logic [WIDTH-1:0] r_wdata, r_wmask, w_wdata, w_wmask;
    logic             w_we, w_in_range, w_done, w_drive;
    logic [DEPTH-1:0] w_onehot;

    logic             r_req_ready, r_rsp_valid, r_rsp_err, r_sa_en;
    logic [WIDTH-1:0] r_rsp_rdata, r_wd_en, r_wd_data;
    logic [DEPTH-1:0] r_row_wr, r_row_rd;

    // In IDLE the live request feeds the decoder so the first SETUP cycle is already qualified.
    always_comb begin
        if (r_state == IDLE) begin
            w_we    = req_we;
            w_addr  = req_addr;
            w_wdata = req_wdata;
            w_wmask = req_wmask;
        end else begin
            w_we    = (r_op == OP_WR);
            w_addr  = r_addr;
            w_wdata = r_wdata;
            w_wmask = r_wmask;
        end
    end

    sram_row_decoder #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_row_dec (
        .i_addr     (w_addr),
        .i_en       (w_state_nxt == PULSE),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    // Next state; the phase counter reloads on every state entry and counts down to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_acc       = 1'b1;
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = WL_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RECOVER;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            RECOVER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_drive = ((w_state_nxt == SETUP) || (w_state_nxt == PULSE)) && w_we && w_in_range;
    assign w_done  = (r_state == PULSE) && (w_state_nxt == RECOVER);

    // FSM state, phase counter and the request captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_acc) begin
                r_op    <= req_we ? OP_WR : OP_RD;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
            end else begin
                r_op    <= r_op;
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
                r_wmask <= r_wmask;
            end
        end
    end

    // Array-facing and response outputs, registered from the next-state view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_row_wr    <= '0;
            r_row_rd    <= '0;
            r_wd_en     <= '0;
            r_wd_data   <= '0;
            r_sa_en     <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= w_done;
            r_rsp_err   <= w_done && !w_in_range;
            r_rsp_rdata <= (w_done && !w_we && w_in_range) ? sa_out : r_rsp_rdata;
            r_row_wr    <= w_we ? w_onehot : '0;
            r_row_rd    <= w_we ? '0 : w_onehot;
            r_wd_en     <= w_drive ? w_wmask : '0;
            r_wd_data   <= w_drive ? w_wdata : '0;
            r_sa_en     <= (w_state_nxt == PULSE) && !w_we && w_in_range && (w_cnt_nxt < SENSE_TH);
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign row_wr    = r_row_wr;
    assign row_rd    = r_row_rd;
    assign wd_en     = r_wd_en;
    assign wd_data   = r_wd_data;
    assign sa_en     = r_sa_en;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench for sram_array_ctrl: a request-level timing/memory model checked
// every cycle, plus hand-computed expectations for each directed scenario.
module tb_sram_array_ctrl;

    localparam int D = 4;
    localparam int S = 1;
    localparam int WL = 3;
    localparam int SE = 1;
    localparam int G = 2;
    localparam int T = S + WL + G;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0, req_we = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [3:0] req_wdata = 4'h0, req_wmask = 4'h0;
    logic       req_ready, rsp_valid, rsp_err, sa_en;
    logic [3:0] rsp_rdata, row_wr, row_rd, wd_en, wd_data, sa_out;

    logic       b_valid = 1'b0, b_we = 1'b0;
    logic [2:0] b_addr = 3'd0;
    logic [3:0] b_wdata = 4'h0, b_wmask = 4'h0;
    logic       b_ready, b_rv, b_err, b_sa_en;
    logic [3:0] b_rdata, b_wd_en, b_wd_data, b_sa_out;
    logic [5:0] b_row_wr, b_row_rd;

    sram_array_ctrl #(.WIDTH(4), .DEPTH(D), .SETUP_CYCLES(S), .WL_CYCLES(WL),
                      .SENSE_CYCLES(SE), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .row_wr(row_wr), .row_rd(row_rd), .wd_en(wd_en), .wd_data(wd_data),
        .sa_en(sa_en), .sa_out(sa_out)
    );

    sram_array_ctrl #(.WIDTH(4), .DEPTH(6), .SETUP_CYCLES(S), .WL_CYCLES(WL),
                      .SENSE_CYCLES(SE), .GAP_CYCLES(G)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_wmask(b_wmask),
        .rsp_valid(b_rv), .rsp_err(b_err), .rsp_rdata(b_rdata),
        .row_wr(b_row_wr), .row_rd(b_row_rd), .wd_en(b_wd_en), .wd_data(b_wd_data),
        .sa_en(b_sa_en), .sa_out(b_sa_out)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Analog cell model: bits under an enabled driver take wd_data while the row is pulsed.
    logic [3:0] cell_mem [0:3] = '{4'h6, 4'hC, 4'h0, 4'h3};
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (row_wr[i]) cell_mem[i] <= (cell_mem[i] & ~wd_en) | (wd_data & wd_en);
    end
    always_comb begin
        sa_out = 4'h0;
        for (int i = 0; i < 4; i++)
            if (sa_en && row_rd[i]) sa_out = cell_mem[i];
    end
    assign b_sa_out = b_sa_en ? 4'hB : 4'h0;

    // Request-level model: position k within an operation decides every output.
    logic [3:0] mem_exp [0:3] = '{4'h6, 4'hC, 4'h0, 4'h3};
    logic       m_busy = 1'b0, m_we = 1'b0;
    int         m_k = 0;
    logic [1:0] m_addr = 2'd0;
    logic [3:0] m_wdata = 4'h0, m_wmask = 4'h0, m_rval = 4'h0, m_rdata = 4'h0;
    logic       m_inr;
    assign m_inr = (int'(m_addr) < D);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_rdata <= 4'h0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  <= 1'b1;
                m_k     <= 1;
                m_we    <= req_we;
                m_addr  <= req_addr;
                m_wdata <= req_wdata;
                m_wmask <= req_wmask;
                m_rval  <= mem_exp[req_addr];
                if (req_we)
                    mem_exp[req_addr] <= (mem_exp[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
            end
        end else begin
            if (m_k == S + WL && !m_we && m_inr) m_rdata <= m_rval;
            if (m_k == T) begin
                m_busy <= 1'b0;
                m_k    <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    int   last_act = 0;
    logic prev_act = 1'b0, seen_pulse = 1'b0;

    // Per-cycle compare of every output against the model, plus wordline spacing.
    always @(negedge clk) begin
        logic       e_setup, e_pulse, e_rv, act;
        logic [3:0] e_oh, e_wen, e_wdat;
        e_setup = m_busy && (m_k >= 1) && (m_k <= S);
        e_pulse = m_busy && (m_k > S) && (m_k <= S + WL);
        e_rv    = m_busy && (m_k == S + WL + 1);
        e_oh    = m_inr ? (4'b0001 << m_addr) : 4'b0000;
        e_wen   = ((e_setup || e_pulse) && m_we && m_inr) ? m_wmask : 4'h0;
        e_wdat  = ((e_setup || e_pulse) && m_we && m_inr) ? m_wdata : 4'h0;
        chk("req_ready", req_ready, !m_busy);
        chk("row_wr", row_wr, (e_pulse && m_we) ? e_oh : 4'h0);
        chk("row_rd", row_rd, (e_pulse && !m_we) ? e_oh : 4'h0);
        chk("wd_en", wd_en, e_wen);
        chk("wd_data", wd_data, e_wdat);
        chk("sa_en", sa_en, e_pulse && !m_we && m_inr && (m_k > S + WL - SE));
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_err", rsp_err, e_rv && !m_inr);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        act = |(row_wr | row_rd);
        if (act && !prev_act && seen_pulse) chk("wl_spacing_ge4", (cyc - last_act - 1) >= 4, 1'b1);
        if (act) begin
            last_act   = cyc;
            seen_pulse = 1'b1;
        end
        prev_act = act;
    end

    logic [7:0] t_rw [1:12], t_rr [1:12];
    logic [3:0] t_wen [1:12], t_wdat [1:12], t_rdat [1:12];
    logic       t_sa [1:12], t_rv [1:12], t_err [1:12], t_rdy [1:12];

    task automatic observe(input bit sel_b, input int n);
        for (int i = 1; i <= n; i++) begin
            t_rw[i]   = sel_b ? 8'(b_row_wr) : 8'(row_wr);
            t_rr[i]   = sel_b ? 8'(b_row_rd) : 8'(row_rd);
            t_wen[i]  = sel_b ? b_wd_en : wd_en;
            t_wdat[i] = sel_b ? b_wd_data : wd_data;
            t_rdat[i] = sel_b ? b_rdata : rsp_rdata;
            t_sa[i]   = sel_b ? b_sa_en : sa_en;
            t_rv[i]   = sel_b ? b_rv : rsp_valid;
            t_err[i]  = sel_b ? b_err : rsp_err;
            t_rdy[i]  = sel_b ? b_ready : req_ready;
            @(negedge clk);
        end
    endtask

    task automatic send(input bit sel_b, input bit we, input int addr,
                        input logic [3:0] wdata, input logic [3:0] wmask);
        int n;
        n = 0;
        @(negedge clk);
        if (sel_b) begin
            b_we = we; b_addr = 3'(addr); b_wdata = wdata; b_wmask = wmask; b_valid = 1'b1;
        end else begin
            req_we = we; req_addr = 2'(addr); req_wdata = wdata; req_wmask = wmask; req_valid = 1'b1;
        end
        while (!(sel_b ? b_ready : req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_bound", n < 50, 1'b1);
        @(negedge clk);
        // Scramble inputs after acceptance; the request must already be latched.
        if (sel_b) begin
            b_valid = 1'b0; b_we = ~we; b_addr = ~b_addr; b_wdata = ~wdata; b_wmask = ~wmask;
        end else begin
            req_valid = 1'b0; req_we = ~we; req_addr = ~req_addr; req_wdata = ~wdata; req_wmask = ~wmask;
        end
    endtask

    initial begin
        int c, f;
        int acc [0:2];
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_row_wr", row_wr, 4'h0);
        chk("rst_wd_en", wd_en, 4'h0);
        chk("rst_rsp_rdata", rsp_rdata, 4'h0);
        rst_n = 1'b1;

        // Write 0xA to row 2, full mask.
        send(1'b0, 1'b1, 2, 4'hA, 4'hF);
        observe(1'b0, 8);
        c = 0; for (int i = 1; i <= 8; i++) if (t_wdat[i] == 4'hA && t_wen[i] == 4'hF) c++;
        chk("wr_drive_cycles", c, 4);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rw[i] == 8'h04) c++;
        chk("wr_row_cycles", c, 3);
        f = 0; for (int i = 8; i >= 1; i--) if (t_rw[i] != 8'h00) f = i;
        chk("wr_row_start", f, 2);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rv[i]) c++;
        chk("wr_rsp_pulses", c, 1);
        f = 0; for (int i = 8; i >= 1; i--) if (t_rdy[i]) f = i;
        chk("wr_ready_return", f, 7);

        // Read row 2 back through the cell model.
        send(1'b0, 1'b0, 2, 4'h0, 4'h0);
        observe(1'b0, 8);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rr[i] == 8'h04) c++;
        chk("rd_row_cycles", c, 3);
        c = 0; for (int i = 1; i <= 8; i++) if (t_sa[i]) c++;
        chk("rd_sa_cycles", c, 1);
        chk("rd_sa_in_third", t_sa[4], 1'b1);
        c = 0; for (int i = 1; i <= 8; i++) if (t_wen[i] != 4'h0) c++;
        chk("rd_wd_en_quiet", c, 0);
        chk("rd_rsp_valid", t_rv[5], 1'b1);
        chk("rd_rsp_err", t_err[5], 1'b0);
        chk("rd_rdata", t_rdat[5], 4'hA);

        // Masked write 0x5/0x3 to row 1 with a request glitch while busy.
        send(1'b0, 1'b1, 1, 4'h5, 4'h3);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        observe(1'b0, 8);
        c = 0; for (int i = 1; i <= 8; i++) if (t_wen[i] == 4'h3 && t_wdat[i] == 4'h5) c++;
        chk("mw_drive_cycles", c, 3);
        send(1'b0, 1'b0, 1, 4'h0, 4'h0);
        observe(1'b0, 8);
        chk("mw_readback", t_rdat[5], 4'hD);

        // Reset during the second pulse cycle of a write.
        send(1'b0, 1'b1, 3, 4'h3, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_row_wr", row_wr, 4'h8);
        rst_n = 1'b0;
        #1;
        chk("async_row_wr", row_wr, 4'h0);
        chk("async_wd_en", wd_en, 4'h0);
        chk("async_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        observe(1'b0, 8);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rv[i]) c++;
        chk("abort_no_rsp", c, 0);
        chk("abort_ready", t_rdy[1], 1'b1);
        send(1'b0, 1'b0, 3, 4'h0, 4'h0);
        observe(1'b0, 8);
        chk("post_rst_rsp", t_rv[5], 1'b1);
        chk("post_rst_rdata", t_rdat[5], 4'h3);

        // Three back-to-back requests with req_valid held high.
        @(negedge clk);
        req_we = 1'b1; req_addr = 2'd0; req_wdata = 4'h9; req_wmask = 4'hF; req_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            int n;
            n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("queue_accept_bound", n < 50, 1'b1);
            @(posedge clk);
            acc[j] = cyc;
            @(negedge clk);
            if (j == 0) begin
                req_we = 1'b0; req_addr = 2'd3;
            end else if (j == 1) begin
                req_we = 1'b0; req_addr = 2'd0;
            end else begin
                req_valid = 1'b0;
            end
        end
        chk("queue_gap_01", acc[1] - acc[0], 7);
        chk("queue_gap_12", acc[2] - acc[1], 7);
        repeat (8) @(negedge clk);
        chk("queue_last_rdata", rsp_rdata, 4'h9);

        // DEPTH=6 build: in-range read, then out-of-range address 7.
        send(1'b1, 1'b0, 5, 4'h0, 4'h0);
        observe(1'b1, 8);
        chk("b_rd5_rdata", t_rdat[5], 4'hB);
        chk("b_rd5_err", t_err[5], 1'b0);
        send(1'b1, 1'b0, 7, 4'h0, 4'h0);
        observe(1'b1, 8);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rv[i] && t_err[i]) c++;
        chk("oor_valid_err", c, 1);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rv[i] != t_err[i]) c++;
        chk("oor_err_aligned", c, 0);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rr[i] != 8'h00 || t_rw[i] != 8'h00 || t_sa[i] || t_wen[i] != 4'h0) c++;
        chk("oor_no_activity", c, 0);
        c = 0; for (int i = 1; i <= 8; i++) if (t_rdat[i] == 4'hB) c++;
        chk("oor_rdata_held", c, 8);
        f = 0; for (int i = 8; i >= 1; i--) if (t_rdy[i]) f = i;
        chk("oor_ready_return", f, 7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
